// File: rtl/mips_pkg.sv
// Shared widths, ALU opcodes and forward-select encodings for the
// ID/EX operand stage and its forwarding muxes.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int ALUC_W = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Combinational RAW bypass for one operand: MEM beats WB beats the
// registered value, and register 0 is never bypassed.
module fwd_mux #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int RA_W   = mips_pkg::RA_W
) (
  input  logic [RA_W-1:0]   addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        sel
);
  import mips_pkg::*;

  logic addr_nonzero;
  logic mem_hit;
  logic wb_hit;

  assign addr_nonzero = (addr != {RA_W{1'b0}});
  assign mem_hit      = mem_reg_write && addr_nonzero && (mem_rd_addr == addr);
  assign wb_hit       = wb_reg_write  && addr_nonzero && (wb_rd_addr  == addr);

  // Select the youngest producer of this operand
  always_comb begin
    data = reg_data;
    sel  = FWD_REG;
    if (mem_hit) begin
      data = mem_result;
      sel  = FWD_MEM;
    end else if (wb_hit) begin
      data = wb_result;
      sel  = FWD_WB;
    end else begin
      data = reg_data;
      sel  = FWD_REG;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decode, forwards from
// MEM/WB, and inserts one bubble per load-use hazard.
module id_ex_operand_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int RA_W   = mips_pkg::RA_W,
  parameter int ALUC_W = mips_pkg::ALUC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic              id_alu_src,
  input  logic [ALUC_W-1:0] id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_hold,
  input  logic              ex_flush,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              id_stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  import mips_pkg::*;

  logic              valid_r;
  logic [DATA_W-1:0] rs_data_r;
  logic [DATA_W-1:0] rt_data_r;
  logic [DATA_W-1:0] imm_r;
  logic [RA_W-1:0]   rs_addr_r;
  logic [RA_W-1:0]   rt_addr_r;
  logic [RA_W-1:0]   rd_addr_r;
  logic              alu_src_r;
  logic [ALUC_W-1:0] alu_ctrl_r;
  logic              reg_write_r;
  logic              mem_read_r;
  logic              mem_write_r;

  logic              load_use_s;
  logic              clear_s;
  logic [DATA_W-1:0] rs_fwd_s;
  logic [DATA_W-1:0] rt_fwd_s;
  logic [1:0]        rs_sel_s;
  logic [1:0]        rt_sel_s;

  // rt only matters when it is read as a register operand or as store data
  assign load_use_s = valid_r && mem_read_r && id_valid &&
                      (rd_addr_r != {RA_W{1'b0}}) &&
                      ((rd_addr_r == id_rs_addr) ||
                       ((rd_addr_r == id_rt_addr) && (!id_alu_src || id_mem_write)));

  // A held stage cannot accept a bubble, so the hazard waits for the release
  assign id_stall = load_use_s && !ex_hold;
  assign clear_s  = !rst_n || ex_flush || id_stall;

  // Stage registers: reset/flush/bubble clear, hold keeps, otherwise capture
  always_ff @(posedge clk) begin
    if (clear_s) begin
      valid_r     <= 1'b0;
      rs_data_r   <= {DATA_W{1'b0}};
      rt_data_r   <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      rs_addr_r   <= {RA_W{1'b0}};
      rt_addr_r   <= {RA_W{1'b0}};
      rd_addr_r   <= {RA_W{1'b0}};
      alu_src_r   <= 1'b0;
      alu_ctrl_r  <= {ALUC_W{1'b0}};
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (!ex_hold) begin
      valid_r     <= id_valid;
      rs_data_r   <= id_rs_data;
      rt_data_r   <= id_rt_data;
      imm_r       <= id_imm;
      rs_addr_r   <= id_rs_addr;
      rt_addr_r   <= id_rt_addr;
      rd_addr_r   <= id_rd_addr;
      alu_src_r   <= id_alu_src;
      alu_ctrl_r  <= id_alu_ctrl;
      reg_write_r <= id_reg_write && id_valid;
      mem_read_r  <= id_mem_read  && id_valid;
      mem_write_r <= id_mem_write && id_valid;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .addr          (rs_addr_r),
    .reg_data      (rs_data_r),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .data          (rs_fwd_s),
    .sel           (rs_sel_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .addr          (rt_addr_r),
    .reg_data      (rt_data_r),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .data          (rt_fwd_s),
    .sel           (rt_sel_s)
  );

  // Operand assembly; a FWD_REG select takes the register path directly
  always_comb begin
    alu_a         = (rs_sel_s == FWD_REG) ? rs_data_r : rs_fwd_s;
    ex_store_data = (rt_sel_s == FWD_REG) ? rt_data_r : rt_fwd_s;
    alu_b         = ex_store_data;
    if (alu_src_r) begin
      alu_b = imm_r;
    end else begin
      alu_b = ex_store_data;
    end
  end

  assign alu_ctrl     = alu_ctrl_r;
  assign ex_valid     = valid_r;
  assign ex_rd_addr   = rd_addr_r;
  assign ex_reg_write = reg_write_r && valid_r;
  assign ex_mem_read  = mem_read_r  && valid_r;
  assign ex_mem_write = mem_write_r && valid_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, forwarding,
// load-use bubbles, immediate select, hold and flush.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_alu_src;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        ex_hold, ex_flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic        id_stall;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_hold(ex_hold), .ex_flush(ex_flush),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs_data = 32'h0; id_rt_data = 32'h0; id_imm = 32'h0;
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rd_addr = 5'd0;
    id_alu_src = 1'b0; id_alu_ctrl = 3'b000;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    ex_hold = 1'b0; ex_flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_result = 32'h0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    id_valid = 1'b1; id_rs_data = 32'd5; id_rt_data = 32'd7;
    id_alu_ctrl = 3'b010; id_reg_write = 1'b1;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
    checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_b got=%h exp=0", alu_b); end
    checks++; if (alu_ctrl !== 3'b000) begin errors++; $display("FAIL reset_alu_ctrl got=%b exp=000", alu_ctrl); end
    checks++; if ({id_stall, ex_reg_write} !== 2'b00) begin errors++; $display("FAIL reset_ctrl got=%b exp=00", {id_stall, ex_reg_write}); end
    rst_n = 1'b1;
    tick();
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL capture_alu_a got=%h exp=5", alu_a); end
    checks++; if (alu_b !== 32'd7) begin errors++; $display("FAIL capture_alu_b got=%h exp=7", alu_b); end
    checks++; if ({ex_valid, ex_reg_write, alu_ctrl} !== 5'b11_010) begin errors++; $display("FAIL capture_ctrl got=%b exp=11010", {ex_valid, ex_reg_write, alu_ctrl}); end
  endtask

  task automatic test_forward_priority();
    idle();
    id_valid = 1'b1; id_rs_addr = 5'd3; id_rs_data = 32'h99; id_rt_addr = 5'd3; id_rt_data = 32'h98;
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd3; wb_result  = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h11) begin errors++; $display("FAIL fwd_mem_prio got=%h exp=11", alu_a); end
    checks++; if (ex_store_data !== 32'h11) begin errors++; $display("FAIL fwd_mem_rt got=%h exp=11", ex_store_data); end
    mem_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== 32'h22) begin errors++; $display("FAIL fwd_wb got=%h exp=22", alu_a); end
    mem_reg_write = 1'b1; mem_rd_addr = 5'd4;
    #1;
    checks++; if (alu_b !== 32'h22) begin errors++; $display("FAIL fwd_wb_rt_addr_miss got=%h exp=22", alu_b); end
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== 32'h99) begin errors++; $display("FAIL fwd_none got=%h exp=99", alu_a); end
  endtask

  task automatic test_reg_zero();
    idle();
    id_valid = 1'b1;
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hFF;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hEE;
    #1;
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reg0_alu_a got=%h exp=0", alu_a); end
    checks++; if (ex_store_data !== 32'h0) begin errors++; $display("FAIL reg0_store got=%h exp=0", ex_store_data); end
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd4;
    id_rs_addr = 5'd1; id_alu_src = 1'b1; id_imm = 32'h8;
    tick();
    checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL lu_load_in_ex got=%b exp=1", ex_mem_read); end
    id_mem_read = 1'b0; id_alu_src = 1'b0; id_rd_addr = 5'd6; id_alu_ctrl = 3'b001;
    id_rs_addr = 5'd4; id_rs_data = 32'hDEAD; id_rt_addr = 5'd2; id_rt_data = 32'h5;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin errors++; $display("FAIL lu_bubble got=%b exp=000", {ex_valid, ex_reg_write, ex_mem_read}); end
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_single_bubble got=%b exp=0", id_stall); end
    tick();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'hCAFE;
    #1;
    checks++; if ({ex_valid, ex_rd_addr} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_dep_captured got=%b exp=%b", {ex_valid, ex_rd_addr}, {1'b1, 5'd6}); end
    checks++; if (alu_a !== 32'hCAFE) begin errors++; $display("FAIL lu_wb_fwd got=%h exp=cafe", alu_a); end
    checks++; if (alu_b !== 32'h5) begin errors++; $display("FAIL lu_alu_b got=%h exp=5", alu_b); end
  endtask

  task automatic test_load_use_rt();
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd4;
    tick();
    id_mem_read = 1'b0; id_rd_addr = 5'd9; id_rs_addr = 5'd1; id_rt_addr = 5'd4; id_alu_src = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_rt_imm got=%b exp=0", id_stall); end
    id_mem_write = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_store got=%b exp=1", id_stall); end
    id_mem_write = 1'b0; id_alu_src = 1'b0;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_reg got=%b exp=1", id_stall); end
    id_valid = 1'b0;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_id_invalid got=%b exp=0", id_stall); end
  endtask

  task automatic test_imm_select();
    idle();
    id_valid = 1'b1; id_alu_src = 1'b1; id_imm = 32'hFFFFFFF0; id_mem_write = 1'b1;
    id_rt_addr = 5'd5; id_rt_data = 32'd9;
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'h1234;
    #1;
    checks++; if (alu_b !== 32'hFFFFFFF0) begin errors++; $display("FAIL imm_alu_b got=%h exp=fffffff0", alu_b); end
    checks++; if (ex_store_data !== 32'h1234) begin errors++; $display("FAIL imm_store got=%h exp=1234", ex_store_data); end
    checks++; if (ex_mem_write !== 1'b1) begin errors++; $display("FAIL imm_mem_write got=%b exp=1", ex_mem_write); end
  endtask

  task automatic test_hold_flush();
    idle();
    id_valid = 1'b1; id_rs_addr = 5'd7; id_rs_data = 32'h70; id_rt_addr = 5'd8; id_rt_data = 32'h80;
    id_alu_ctrl = 3'b101; id_reg_write = 1'b1; id_rd_addr = 5'd9;
    tick();
    ex_hold = 1'b1; id_rs_data = 32'h1; id_rt_data = 32'h2; id_alu_ctrl = 3'b000; id_rd_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, alu_ctrl, ex_rd_addr, alu_a, alu_b} !== {1'b1, 1'b1, 3'b101, 5'd9, 32'h70, 32'h80}) begin
        errors++; $display("FAIL hold_cycle%0d got a=%h b=%h ctrl=%b rd=%0d", i, alu_a, alu_b, alu_ctrl, ex_rd_addr);
      end
    end
    ex_flush = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_reg_write} !== 2'b00) begin errors++; $display("FAIL flush_over_hold got=%b exp=00", {ex_valid, ex_reg_write}); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL flush_clear got=%h exp=0", alu_a); end
  endtask

  task automatic test_hold_vs_stall();
    idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd4;
    tick();
    id_mem_read = 1'b0; id_rd_addr = 5'd6; id_rs_addr = 5'd4; ex_hold = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL hold_masks_stall got=%b exp=0", id_stall); end
    tick();
    checks++; if ({ex_mem_read, ex_rd_addr} !== {1'b1, 5'd4}) begin errors++; $display("FAIL hold_keeps_load got=%b", {ex_mem_read, ex_rd_addr}); end
    ex_hold = 1'b0;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL stall_after_hold got=%b exp=1", id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_after_hold got=%b exp=0", ex_valid); end
  endtask

  task automatic test_back_to_back();
    idle();
    id_valid = 1'b1; id_rs_data = 32'h100; id_rt_data = 32'h101; id_alu_ctrl = 3'b111;
    tick();
    checks++; if ({alu_a, alu_ctrl} !== {32'h100, 3'b111}) begin errors++; $display("FAIL b2b_first got=%h/%b", alu_a, alu_ctrl); end
    id_rs_data = 32'h200; id_rt_data = 32'h201; id_alu_ctrl = 3'b110;
    tick();
    checks++; if ({alu_a, alu_b, alu_ctrl} !== {32'h200, 32'h201, 3'b110}) begin errors++; $display("FAIL b2b_second got=%h/%h/%b", alu_a, alu_b, alu_ctrl); end
    id_valid = 1'b0; id_reg_write = 1'b1; id_mem_write = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b000) begin errors++; $display("FAIL invalid_ctrl_masked got=%b exp=000", {ex_valid, ex_reg_write, ex_mem_write}); end
  endtask

  task automatic test_reset_midop();
    idle();
    id_valid = 1'b1; id_rs_data = 32'h55; id_reg_write = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if ({ex_valid, ex_reg_write, alu_a} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL reset_midop got v=%b a=%h", ex_valid, alu_a); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_reg_zero();
    test_load_use();
    test_load_use_rt();
    test_imm_select();
    test_hold_flush();
    test_hold_vs_stall();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
